// File: rtl/ex_muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer beside the EX stage.
// Runs MUL/MULHU/DIVU/REMU in a fixed XLEN-cycle loop, stalls the front
// of the pipeline while busy and strobes the result for one cycle.
module ex_muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [4:0]      req_rd_addr,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_rd_addr
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        op;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [4:0]        rd_q;
    // acc: product high half (multiply) or partial remainder (divide)
    // lo : product low half / multiplier, or dividend shifting into quotient
    logic [XLEN:0]     acc;
    logic [XLEN-1:0]   lo;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   res_sel;

    // One shift-add (multiply) and one restoring trial subtract (divide) step
    always_comb begin
        mul_sum   = acc + {1'b0, (lo[0] ? a_q : {XLEN{1'b0}})};
        div_shift = {acc[XLEN-1:0], lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = (div_shift >= {1'b0, b_q});
    end

    // Sequencer state, operand latches and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rd_q  <= '0;
            acc   <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        op    <= req_op;
                        a_q   <= req_a;
                        b_q   <= req_b;
                        rd_q  <= req_rd_addr;
                        acc   <= '0;
                        lo    <= req_op[1] ? req_a : req_b;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        if (op[1]) begin
                            acc <= div_ge ? div_diff : div_shift;
                            lo  <= {lo[XLEN-2:0], div_ge};
                        end else begin
                            acc <= {1'b0, mul_sum[XLEN:1]};
                            lo  <= {mul_sum[0], lo[XLEN-1:1]};
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_ITER) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Odd ops (MULHU, REMU) take the upper/remainder register
    always_comb begin
        res_sel = op[0] ? acc[XLEN-1:0] : lo;
    end

    // Pipeline-facing controls; flush and reset take effect in the same cycle
    always_comb begin
        stall          = rst_n && !flush &&
                         (((state == ST_IDLE) && req_valid) || (state == ST_RUN));
        busy           = (state != ST_IDLE);
        result_valid   = (state == ST_DONE) && !flush;
        result         = result_valid ? res_sel : {XLEN{1'b0}};
        result_rd_addr = result_valid ? rd_q : 5'd0;
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: scoreboard of expected results,
// latency/stall counting, flush and reset-abort scenarios.
module tb_ex_muldiv_seq;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [4:0]      req_rd_addr;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      result_rd_addr;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [4:0]      rd;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    ex_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_rd_addr    (req_rd_addr),
        .flush          (flush),
        .stall          (stall),
        .busy           (busy),
        .result_valid   (result_valid),
        .result         (result),
        .result_rd_addr (result_rd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour from plain arithmetic operators
    function automatic logic [XLEN-1:0] model(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        case (op)
            2'd0:    return p[XLEN-1:0];
            2'd1:    return p[2*XLEN-1:XLEN];
            2'd2:    return (b == '0) ? {XLEN{1'b1}} : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0;
        req_rd_addr = 5'd0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({stall, busy, result_valid} !== 3'b000 || result !== '0 || result_rd_addr !== 5'd0) begin
            failures++;
            $display("FAIL reset_outputs: stall=%b busy=%b rv=%b result=%h rd=%0d, required all 0",
                     stall, busy, result_valid, result, result_rd_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one op and follow it to completion (flush_at==0) or abort it
    // with flush at sample index flush_at (0 is the accept cycle T0).
    task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [4:0] rd,
                          input int flush_at, input string name);
        int   cycles;
        int   stalls;
        bit   done;
        exp_t e;
        if (flush_at == 0) sb.push_back('{res: model(op, a, b), rd: rd});
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd_addr = rd;
        #1;
        cycles = 0; stalls = 0; done = 1'b0;
        while (!done && cycles < 60) begin
            if (flush_at != 0 && cycles == flush_at) begin
                flush = 1'b1;
                #1;
                checks++;
                if (stall !== 1'b0 || result_valid !== 1'b0 || result !== '0) begin
                    failures++;
                    $display("FAIL %s_flush_cycle: stall=%b rv=%b result=%h, required 0 0 0",
                             name, stall, result_valid, result);
                end
                done = 1'b1;
            end else begin
                if (stall === 1'b1) stalls++;
                if (result_valid === 1'b1) begin
                    done = 1'b1;
                    checks++;
                    if (flush_at != 0) begin
                        failures++;
                        $display("FAIL %s_early_result: result_valid at cycle %0d before flush at %0d",
                                 name, cycles, flush_at);
                    end else begin
                        e = sb.pop_front();
                        if (result !== e.res || result_rd_addr !== e.rd) begin
                            failures++;
                            $display("FAIL %s_result: got %h rd=%0d, required %h rd=%0d",
                                     name, result, result_rd_addr, e.res, e.rd);
                        end
                        checks++;
                        if (cycles != 33 || stalls != 33 || stall !== 1'b0 || busy !== 1'b1) begin
                            failures++;
                            $display("FAIL %s_latency: done at T%0d stall_cycles=%0d stall=%b busy=%b, required T33 33 0 1",
                                     name, cycles, stalls, stall, busy);
                        end
                    end
                end
            end
            if (!done) begin
                @(negedge clk);
                req_a = $urandom; req_b = $urandom;
                req_op = 2'($urandom); req_rd_addr = 5'($urandom);
                #1;
                cycles++;
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no result_valid within 60 cycles", name);
        end
        if (flush_at != 0) begin
            @(negedge clk);
            flush = 1'b0; req_valid = 1'b0;
            #1;
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s_idle_after_flush: busy=%b, required 0", name, busy);
            end
            stalls = 0;
            repeat (40) begin
                @(negedge clk); #1;
                if (result_valid !== 1'b0 || stall !== 1'b0) stalls++;
            end
            checks++;
            if (stalls != 0) begin
                failures++;
                $display("FAIL %s_quiet_after_flush: %0d cycles with activity, required 0", name, stalls);
            end
        end
    endtask

    // Cycle after DONE: back in IDLE with outputs cleared
    task automatic finish_idle(input string name);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== '0 || result_rd_addr !== 5'd0) begin
            failures++;
            $display("FAIL %s_idle: busy=%b rv=%b result=%h rd=%0d, required 0 0 0 0",
                     name, busy, result_valid, result, result_rd_addr);
        end
    endtask

    task automatic test_mul();
        run_op(2'd0, 32'd7, 32'd6, 5'd5, 0, "mul_7x6");
        finish_idle("mul_7x6");
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 0, "mulhu_max");
        finish_idle("mulhu_max");
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0, "mul_max");
        finish_idle("mul_max");
    endtask

    task automatic test_div();
        run_op(2'd2, 32'd100, 32'd7, 5'd1, 0, "divu_100_7");
        finish_idle("divu_100_7");
        run_op(2'd3, 32'd100, 32'd7, 5'd2, 0, "remu_100_7");
        finish_idle("remu_100_7");
        run_op(2'd2, 32'h8000_0000, 32'd1, 5'd3, 0, "divu_msb_1");
        finish_idle("divu_msb_1");
    endtask

    task automatic test_div_by_zero();
        run_op(2'd2, 32'h0000_1234, 32'd0, 5'd4, 0, "divu_zero");
        finish_idle("divu_zero");
        run_op(2'd3, 32'h0000_1234, 32'd0, 5'd6, 0, "remu_zero");
        finish_idle("remu_zero");
    endtask

    task automatic test_flush();
        run_op(2'd2, 32'd1000, 32'd3, 5'd7, 10, "divu_flush_run");
        run_op(2'd0, 32'd5, 32'd5, 5'd8, 33, "mul_flush_done");
        // flush with a request in IDLE: nothing accepted
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_op = 2'd0; req_a = 32'd2; req_b = 32'd2;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL idle_flush_stall: stall=%b, required 0", stall);
        end
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_flush_accept: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_a = 32'd11; req_b = 32'd13; req_rd_addr = 5'd12;
        repeat (15) @(negedge clk);
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        checks++;
        if ({stall, busy, result_valid} !== 3'b000 || result !== '0 || result_rd_addr !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid_op: stall=%b busy=%b rv=%b result=%h rd=%0d, required all 0",
                     stall, busy, result_valid, result, result_rd_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(2'd0, 32'd3, 32'd3, 5'd13, 0, "mul_after_reset");
        finish_idle("mul_after_reset");
    endtask

    task automatic test_back_to_back();
        run_op(2'd2, 32'hDEAD_BEEF, 32'd255, 5'd14, 0, "b2b_first");
        run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 0, "b2b_second");
        finish_idle("b2b_second");
    endtask

    task automatic test_random();
        logic [XLEN-1:0] b;
        for (int i = 0; i < 8; i++) begin
            b = (i % 4 == 3) ? '0 : ((i % 2 == 0) ? XLEN'($urandom_range(1, 50)) : XLEN'($urandom));
            run_op(2'(i), $urandom, b, 5'($urandom), 0, "random");
            finish_idle("random");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_by_zero();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
